xfer_sched: RTL and testbench

Transfer scheduler for the REU DMA engine. Decodes C64 writes to the command register, holds the transfer armed until the $FF00 trigger when required, and issues a one-cycle `Execute` to the DMA sequencer. It tracks the transfer to completion, fires the autoload reload strobe, and maintains the sticky status and interrupt flags. It sits between the register-file address decode and the DMA sequencer, and is clocked on the same PHI2 falling edge.

---
 rtl/reu_pkg.sv | 31 +++
 rtl/xfer_status.sv | 46 ++++
 rtl/xfer_sched.sv | 147 ++++++++++++++
 tb/tb_xfer_sched.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/reu_pkg.sv
// Shared definitions for the REU DMA engine: scheduler state encoding,
// command/mask register bit positions and transfer-type codes.
package reu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam int CMD_EXEC     = 7;
    localparam int CMD_AUTOLOAD = 5;
    localparam int CMD_NOFF00   = 4;

    localparam int MASK_GLOBAL  = 7;
    localparam int MASK_EOB     = 6;
    localparam int MASK_VERR    = 5;

    localparam logic [1:0] XFER_C64REU = 2'b00;
    localparam logic [1:0] XFER_REUC64 = 2'b01;
    localparam logic [1:0] XFER_SWAP   = 2'b10;
    localparam logic [1:0] XFER_VERIFY = 2'b11;

    // Interrupt request from the stored {global, eob, verr} enables and the sticky flags.
    function automatic logic irq_calc(input logic [2:0] mask, input logic eob, input logic verr);
        return mask[2] & ((mask[1] & eob) | (mask[0] & verr));
    endfunction

endpackage

// File: rtl/xfer_status.sv
// Sticky EOB / VerifyErr flags, interrupt-mask register and Status/IRQ assembly.
module xfer_status
    import reu_pkg::*;
#(
    parameter logic [3:0] VERSION  = 4'h0,
    parameter logic       SIZE_BIT = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_mask_wr,
    input  logic       i_status_rd,
    input  logic [7:0] i_wrd,
    input  logic       i_set_eob,
    input  logic       i_set_verr,
    output logic [7:0] o_status,
    output logic       o_irq
);

    logic [2:0] r_mask;
    logic       r_eob;
    logic       r_verr;
    logic       w_irq;
    logic       w_unused;

    assign w_unused = &{1'b0, i_wrd[4:0]};

    // Mask register and sticky flags; a set in the same cycle as a read-clear wins.
    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mask <= 3'b000;
            r_eob  <= 1'b0;
            r_verr <= 1'b0;
        end else begin
            if (i_mask_wr) begin
                r_mask <= {i_wrd[MASK_GLOBAL], i_wrd[MASK_EOB], i_wrd[MASK_VERR]};
            end
            r_eob  <= i_set_eob  | (r_eob  & ~i_status_rd);
            r_verr <= i_set_verr | (r_verr & ~i_status_rd);
        end
    end

    assign w_irq    = irq_calc(r_mask, r_eob, r_verr);
    assign o_irq    = w_irq;
    assign o_status = {w_irq, r_eob, r_verr, SIZE_BIT, VERSION};

endmodule

// File: rtl/xfer_sched.sv
// REU transfer scheduler: command decode, optional $FF00 trigger arming
// (built when XFER_SCHED_FF00_EN is defined), Execute/Autoload strobes.
module xfer_sched
    import reu_pkg::*;
#(
    parameter logic [3:0] VERSION  = 4'h0,
    parameter logic       SIZE_BIT = 1'b1
) (
    input  logic       PHI2,
    input  logic       RESET,
    input  logic       CmdWR,
    input  logic       IMaskWR,
    input  logic       FF00WR,
    input  logic       StatusRD,
    input  logic [7:0] WRD,
    input  logic       DMA,
    input  logic       XferEnd,
    input  logic       SetEndOfBlock,
    input  logic       SetVerifyErr,
    output logic       Execute,
    output logic [1:0] XferType,
    output logic       Autoload,
    output logic       Busy,
    output logic [7:0] Status,
    output logic       IRQ
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_type;
    logic       r_autoload;
    logic       w_cmd_accept;
    logic       w_mask_wr;
    logic       w_execute;
    logic       w_autoload;
    logic       w_busy;
    logic       w_unused;

`ifdef XFER_SCHED_FF00_EN
    assign w_unused = &{1'b0, DMA};
`else
    assign w_unused = &{1'b0, DMA, FF00WR};
`endif

    assign w_cmd_accept = CmdWR & ((r_state == ST_IDLE) | (r_state == ST_ARMED));
    assign w_mask_wr    = IMaskWR & (r_state != ST_RUN);

    // State register.
    always_ff @(negedge PHI2 or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Command latch: type and autoload only move on a command taken in IDLE/ARMED.
    always_ff @(negedge PHI2 or posedge RESET) begin
        if (RESET) begin
            r_type     <= XFER_C64REU;
            r_autoload <= 1'b0;
        end else if (w_cmd_accept) begin
            r_type     <= WRD[1:0];
            r_autoload <= WRD[CMD_AUTOLOAD];
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (CmdWR && WRD[CMD_EXEC]) begin
`ifdef XFER_SCHED_FF00_EN
                    w_next = WRD[CMD_NOFF00] ? ST_LAUNCH : ST_ARMED;
`else
                    w_next = ST_LAUNCH;
`endif
                end else begin
                    w_next = ST_IDLE;
                end
            end
`ifdef XFER_SCHED_FF00_EN
            ST_ARMED: begin
                // A command write in the same cycle overrides the trigger.
                if (CmdWR) begin
                    if (!WRD[CMD_EXEC]) begin
                        w_next = ST_IDLE;
                    end else if (WRD[CMD_NOFF00]) begin
                        w_next = ST_LAUNCH;
                    end else begin
                        w_next = ST_ARMED;
                    end
                end else if (FF00WR) begin
                    w_next = ST_LAUNCH;
                end else begin
                    w_next = ST_ARMED;
                end
            end
`endif
            ST_LAUNCH: w_next = ST_RUN;
            ST_RUN: begin
                if (XferEnd) begin
                    w_next = r_autoload ? ST_FINISH : ST_IDLE;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        w_execute  = 1'b0;
        w_autoload = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            ST_IDLE:   w_busy     = 1'b0;
            ST_LAUNCH: w_execute  = 1'b1;
            ST_FINISH: w_autoload = 1'b1;
            default:   w_busy     = 1'b1;
        endcase
    end

    assign Execute  = w_execute;
    assign Autoload = w_autoload;
    assign Busy     = w_busy;
    assign XferType = r_type;

    xfer_status #(
        .VERSION  (VERSION),
        .SIZE_BIT (SIZE_BIT)
    ) u_status (
        .i_clk       (PHI2),
        .i_rst       (RESET),
        .i_mask_wr   (w_mask_wr),
        .i_status_rd (StatusRD),
        .i_wrd       (WRD),
        .i_set_eob   (SetEndOfBlock),
        .i_set_verr  (SetVerifyErr),
        .o_status    (Status),
        .o_irq       (IRQ)
    );

endmodule

// File: tb/tb_xfer_sched.sv
// Directed table-driven bench for xfer_sched plus hand sequences for the
// $FF00 trigger, cancel and reset-in-RUN cases (both build options).
module tb_xfer_sched;

    logic       PHI2 = 1'b1;
    logic       RESET;
    logic       CmdWR, IMaskWR, FF00WR, StatusRD, DMA, XferEnd, SetEndOfBlock, SetVerifyErr;
    logic [7:0] WRD;
    logic       Execute, Autoload, Busy, IRQ;
    logic [1:0] XferType;
    logic [7:0] Status;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exec_cnt;

`ifdef XFER_SCHED_FF00_EN
    localparam bit FF00 = 1'b1;
`else
    localparam bit FF00 = 1'b0;
`endif

    always #5 PHI2 = ~PHI2;

    xfer_sched dut (
        .PHI2(PHI2), .RESET(RESET), .CmdWR(CmdWR), .IMaskWR(IMaskWR), .FF00WR(FF00WR),
        .StatusRD(StatusRD), .WRD(WRD), .DMA(DMA), .XferEnd(XferEnd),
        .SetEndOfBlock(SetEndOfBlock), .SetVerifyErr(SetVerifyErr),
        .Execute(Execute), .XferType(XferType), .Autoload(Autoload), .Busy(Busy),
        .Status(Status), .IRQ(IRQ)
    );

    typedef struct {
        logic       cmdwr, imaskwr, ff00wr, statusrd;
        logic [7:0] wrd;
        logic       xferend, seteob, setverr;
        logic       e_exec;
        logic [1:0] e_type;
        logic       e_auto, e_busy;
        logic [7:0] e_status;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clr_in();
        CmdWR = 1'b0; IMaskWR = 1'b0; FF00WR = 1'b0; StatusRD = 1'b0; WRD = 8'h00;
        DMA = 1'b0; XferEnd = 1'b0; SetEndOfBlock = 1'b0; SetVerifyErr = 1'b0;
    endtask

    task automatic tick();
        @(negedge PHI2);
        #1;
        if (Execute === 1'b1) exec_cnt++;
        clr_in();
    endtask

    initial begin
        clr_in();
        RESET = 1'b1;
        #2;
        chk("rst_exec", {7'd0, Execute}, 8'h00);
        chk("rst_auto", {7'd0, Autoload}, 8'h00);
        chk("rst_busy", {7'd0, Busy}, 8'h00);
        chk("rst_type", {6'd0, XferType}, 8'h00);
        chk("rst_status", Status, 8'h10);
        chk("rst_irq", {7'd0, IRQ}, 8'h00);
        @(negedge PHI2); #1;
        RESET = 1'b0;

        //         cmd  msk  ff   rd   wrd    end  eob  ver  ex   type   au   bsy  status
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,8'h10};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,8'h90,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b1,8'h10};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,8'h10};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,8'h10};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,8'h10};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,8'hA0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,8'h10};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,8'hB3,1'b0,1'b0,1'b0,1'b1,2'b11,1'b0,1'b1,8'h10};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,2'b11,1'b0,1'b1,8'hB0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,2'b11,1'b1,1'b1,8'hB0};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,1'b0,8'hB0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1,8'h00,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,1'b0,8'h10};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b0,8'hC0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,1'b0,8'h10};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b1,8'h00,1'b0,1'b1,1'b0,1'b0,2'b11,1'b0,1'b0,8'hD0};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b1,8'h00,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,1'b0,8'h10};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,2'b11,1'b0,1'b0,8'hF0};
        vecs[15] = '{1'b0,1'b0,1'b0,1'b1,8'h00,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,1'b0,8'h10};
        vecs[16] = '{1'b1,1'b0,1'b0,1'b0,8'h02,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,1'b0,8'h10};
        vecs[17] = '{1'b1,1'b0,1'b0,1'b0,8'h91,1'b0,1'b0,1'b0,1'b1,2'b01,1'b0,1'b1,8'h10};
        vecs[18] = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b1,8'h10};
        vecs[19] = '{1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,2'b01,1'b0,1'b1,8'hD0};
        vecs[20] = '{1'b1,1'b0,1'b1,1'b0,8'h90,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b1,8'hD0};
        vecs[21] = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,8'hD0};
        vecs[22] = '{1'b0,1'b0,1'b0,1'b1,8'h00,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,8'h10};

        for (int i = 0; i < 23; i++) begin
            CmdWR = vecs[i].cmdwr; IMaskWR = vecs[i].imaskwr; FF00WR = vecs[i].ff00wr;
            StatusRD = vecs[i].statusrd; WRD = vecs[i].wrd; XferEnd = vecs[i].xferend;
            SetEndOfBlock = vecs[i].seteob; SetVerifyErr = vecs[i].setverr;
            tick();
            chk($sformatf("v%0d_exec", i), {7'd0, Execute}, {7'd0, vecs[i].e_exec});
            chk($sformatf("v%0d_type", i), {6'd0, XferType}, {6'd0, vecs[i].e_type});
            chk($sformatf("v%0d_auto", i), {7'd0, Autoload}, {7'd0, vecs[i].e_auto});
            chk($sformatf("v%0d_busy", i), {7'd0, Busy}, {7'd0, vecs[i].e_busy});
            chk($sformatf("v%0d_status", i), Status, vecs[i].e_status);
            chk($sformatf("v%0d_irq", i), {7'd0, IRQ}, {7'd0, vecs[i].e_status[7]});
        end

        // Deferred trigger: CmdWR 81, FF00WR three cycles later.
        exec_cnt = 0;
        CmdWR = 1'b1; WRD = 8'h81; tick();
        chk("ff_cmd_exec", {7'd0, Execute}, {7'd0, ~FF00});
        chk("ff_cmd_busy", {7'd0, Busy}, 8'h01);
        tick();
        chk("ff_wait1_exec", {7'd0, Execute}, 8'h00);
        tick();
        chk("ff_wait2_exec", {7'd0, Execute}, 8'h00);
        FF00WR = 1'b1; tick();
        chk("ff_trig_exec", {7'd0, Execute}, {7'd0, FF00});
        tick();
        chk("ff_run_exec", {7'd0, Execute}, 8'h00);
        chk("ff_run_busy", {7'd0, Busy}, 8'h01);
        XferEnd = 1'b1; tick();
        chk("ff_end_busy", {7'd0, Busy}, 8'h00);
        chk("ff_pulse_count", exec_cnt[7:0], 8'h01);

        exec_cnt = 0;
`ifdef XFER_SCHED_FF00_EN
        // Cancel from ARMED, then a stray trigger.
        CmdWR = 1'b1; WRD = 8'h80; tick();
        chk("cx_armed_busy", {7'd0, Busy}, 8'h01);
        CmdWR = 1'b1; WRD = 8'h01; tick();
        chk("cx_cancel_busy", {7'd0, Busy}, 8'h00);
        tick();
        FF00WR = 1'b1; tick();
        chk("cx_ff00_busy", {7'd0, Busy}, 8'h00);
        // Cancel and trigger together: the command write wins.
        CmdWR = 1'b1; WRD = 8'h80; tick();
        CmdWR = 1'b1; FF00WR = 1'b1; WRD = 8'h00; tick();
        chk("cx_both_busy", {7'd0, Busy}, 8'h00);
        tick();
        chk("cx_pulse_count", exec_cnt[7:0], 8'h00);
`else
        FF00WR = 1'b1; tick();
        chk("cx_ff00_busy", {7'd0, Busy}, 8'h00);
        chk("cx_pulse_count", exec_cnt[7:0], 8'h00);
`endif

        // Reset in the middle of an autoload transfer with a pending IRQ.
        IMaskWR = 1'b1; WRD = 8'hA0; tick();
        CmdWR = 1'b1; WRD = 8'hB0; tick();
        tick();
        SetVerifyErr = 1'b1; tick();
        chk("rr_pre_status", Status, 8'hB0);
        chk("rr_pre_busy", {7'd0, Busy}, 8'h01);
        #2 RESET = 1'b1;
        #1;
        chk("rr_busy", {7'd0, Busy}, 8'h00);
        chk("rr_exec", {7'd0, Execute}, 8'h00);
        chk("rr_auto", {7'd0, Autoload}, 8'h00);
        chk("rr_type", {6'd0, XferType}, 8'h00);
        chk("rr_status", Status, 8'h10);
        chk("rr_irq", {7'd0, IRQ}, 8'h00);
        #2 RESET = 1'b0;
        XferEnd = 1'b1; tick();
        chk("rr_end_auto", {7'd0, Autoload}, 8'h00);
        chk("rr_end_busy", {7'd0, Busy}, 8'h00);
        SetVerifyErr = 1'b1; tick();
        chk("rr_mask_cleared_status", Status, 8'h30);
        chk("rr_mask_cleared_irq", {7'd0, IRQ}, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
